// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the fetch control path: state encoding, default address
// width and performance-counter geometry.
package fetch_ctrl_pkg;

  localparam int ADDR_W_DEFAULT = 16;
  localparam int PERF_CNT_W     = 16;
  localparam logic [PERF_CNT_W-1:0] PERF_CNT_SAT = 16'hFFFF;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_RUN   = 3'd1;
  localparam state_t ST_STALL = 3'd2;
  localparam state_t ST_FLUSH = 3'd3;
  localparam state_t ST_HALT  = 3'd4;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter used for the fetch performance statistics.
module sat_counter
  import fetch_ctrl_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_inc,
  output logic [PERF_CNT_W-1:0] o_count
);

  logic [PERF_CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != PERF_CNT_SAT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: arbitrates jumps, load-use stalls and debug halt for the PC.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer
  import fetch_ctrl_pkg::*;
#(
  parameter int HAZARD_STALL_CYCLES = 1,
  parameter int ADDR_W              = ADDR_W_DEFAULT
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  jump_req,
  input  logic [ADDR_W-1:0]     jump_addr,
  input  logic                  hazard,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic                  pc_mux_sel,
  output logic [ADDR_W-1:0]     jmp_loc,
  output logic                  stall,
  output logic                  stall_pm,
  output logic                  flush,
  output logic                  jump_ack,
  output logic                  halted,
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [PERF_CNT_W-1:0] jump_count
);

  localparam logic [3:0] STALL_RELOAD = 4'(HAZARD_STALL_CYCLES - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_cnt;
  logic [3:0] w_next_cnt;
  logic       w_jump_accept;
  logic       w_stall;

  // Jumps are only honoured in states where the fetch path is live.
  assign w_jump_accept = !reset && jump_req &&
                         ((r_state == ST_RUN) || (r_state == ST_STALL) || (r_state == ST_FLUSH));

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: w_next_state = ST_RUN;
      ST_RUN: begin
        if (jump_req) begin
          w_next_state = ST_FLUSH;
        end else if (hazard) begin
          w_next_state = ST_STALL;
          w_next_cnt   = STALL_RELOAD;
        end else if (halt_req) begin
          w_next_state = ST_HALT;
        end
      end
      ST_STALL: begin
        if (jump_req) begin
          w_next_state = ST_FLUSH;
          w_next_cnt   = 4'd0;
        end else if (r_cnt == 4'd0) begin
          // A hazard still present at expiry restarts the full stall window.
          if (hazard) begin
            w_next_cnt = STALL_RELOAD;
          end else begin
            w_next_state = ST_RUN;
          end
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      ST_FLUSH: w_next_state = jump_req ? ST_FLUSH : ST_RUN;
      ST_HALT: begin
        if (resume && !halt_req) begin
          w_next_state = ST_RUN;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  assign w_stall    = (r_state == ST_IDLE) || (r_state == ST_STALL) || (r_state == ST_HALT);
  assign stall      = w_stall;
  assign stall_pm   = w_stall;
  assign flush      = (r_state == ST_FLUSH);
  assign halted     = (r_state == ST_HALT);
  assign pc_mux_sel = w_jump_accept;
  assign jump_ack   = w_jump_accept;
  assign jmp_loc    = w_jump_accept ? jump_addr : '0;

`ifdef FETCH_PERF_CNT_EN
  logic w_stall_inc;

  // IDLE stalls are a reset artefact, not pipeline loss, so they are not counted.
  assign w_stall_inc = w_stall && (r_state != ST_IDLE);

  sat_counter u_stall_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_inc   (w_stall_inc),
    .o_count (stall_cycles)
  );

  sat_counter u_jump_cnt (
    .i_clk   (clk),
    .i_reset (reset),
    .i_inc   (w_jump_accept),
    .o_count (jump_count)
  );
`else
  assign stall_cycles = '0;
  assign jump_count   = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a behavioural model queues expected
// outputs per cycle and a negedge monitor compares them against the DUT.
module tb_fetch_sequencer;

  localparam int HSC = 3;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        jumpReq = 1'b0;
  logic [15:0] jumpAddr = 16'h0;
  logic        hazard = 1'b0;
  logic        haltReq = 1'b0;
  logic        resume = 1'b0;
  logic        pcMuxSel, stall, stallPm, flush, jumpAck, halted;
  logic [15:0] jmpLoc, stallCycles, jumpCount;

  always #5 clk = ~clk;

  fetch_sequencer #(.HAZARD_STALL_CYCLES(HSC), .ADDR_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .jump_req     (jumpReq),
    .jump_addr    (jumpAddr),
    .hazard       (hazard),
    .halt_req     (haltReq),
    .resume       (resume),
    .pc_mux_sel   (pcMuxSel),
    .jmp_loc      (jmpLoc),
    .stall        (stall),
    .stall_pm     (stallPm),
    .flush        (flush),
    .jump_ack     (jumpAck),
    .halted       (halted),
    .stall_cycles (stallCycles),
    .jump_count   (jumpCount)
  );

  typedef struct {
    logic        pcSel;
    logic [15:0] jmpLoc;
    logic        ack;
    logic        stall;
    logic        stallPm;
    logic        flush;
    logic        halted;
    logic [15:0] stallCycles;
    logic [15:0] jumpCount;
    int          cycle;
  } expect_t;

  typedef enum {M_IDLE, M_RUN, M_STALL, M_FLUSH, M_HALT} mode_e;

  expect_t expQ[$];
  mode_e   mode = M_IDLE;
  int      stallLeft = 0;
  int      modelStallCnt = 0;
  int      modelJumpCnt = 0;
  int      cycleNo = 0;
  int      vectors = 0;
  int      miscompares = 0;

  // Drive one cycle of inputs, queue what the model expects, then advance the model.
  task automatic applyStimulus(input bit r, input bit j, input logic [15:0] a,
                               input bit h, input bit hr, input bit rs);
    expect_t e;
    bit jumpTaken, stallNow;
    @(posedge clk);
    #1;
    reset = r; jumpReq = j; jumpAddr = a; hazard = h; haltReq = hr; resume = rs;
    jumpTaken = !r && j && (mode == M_RUN || mode == M_STALL || mode == M_FLUSH);
    stallNow  = (mode == M_IDLE || mode == M_STALL || mode == M_HALT);
    e.pcSel       = jumpTaken;
    e.jmpLoc      = jumpTaken ? a : 16'h0;
    e.ack         = jumpTaken;
    e.stall       = stallNow;
    e.stallPm     = stallNow;
    e.flush       = (mode == M_FLUSH);
    e.halted      = (mode == M_HALT);
    e.stallCycles = PERF_EN ? 16'(modelStallCnt) : 16'h0;
    e.jumpCount   = PERF_EN ? 16'(modelJumpCnt) : 16'h0;
    e.cycle       = cycleNo;
    expQ.push_back(e);
    cycleNo++;
    if (r) begin
      mode = M_IDLE; stallLeft = 0; modelStallCnt = 0; modelJumpCnt = 0;
    end else begin
      if (stallNow && mode != M_IDLE && modelStallCnt < 65535) modelStallCnt++;
      if (jumpTaken && modelJumpCnt < 65535) modelJumpCnt++;
      case (mode)
        M_IDLE:  mode = M_RUN;
        M_RUN: begin
          if (j) mode = M_FLUSH;
          else if (h) begin mode = M_STALL; stallLeft = HSC; end
          else if (hr) mode = M_HALT;
        end
        M_STALL: begin
          if (j) mode = M_FLUSH;
          else if (stallLeft == 1) begin
            if (h) stallLeft = HSC; else mode = M_RUN;
          end else stallLeft--;
        end
        M_FLUSH: mode = j ? M_FLUSH : M_RUN;
        M_HALT:  if (rs && !hr) mode = M_RUN;
        default: mode = M_IDLE;
      endcase
    end
  endtask

  task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp, input int cyc);
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    vectors++;
    cmp("pc_mux_sel",   16'(pcMuxSel), 16'(e.pcSel),   e.cycle);
    cmp("jmp_loc",      jmpLoc,        e.jmpLoc,       e.cycle);
    cmp("jump_ack",     16'(jumpAck),  16'(e.ack),     e.cycle);
    cmp("stall",        16'(stall),    16'(e.stall),   e.cycle);
    cmp("stall_pm",     16'(stallPm),  16'(e.stallPm), e.cycle);
    cmp("flush",        16'(flush),    16'(e.flush),   e.cycle);
    cmp("halted",       16'(halted),   16'(e.halted),  e.cycle);
    cmp("stall_cycles", stallCycles,   e.stallCycles,  e.cycle);
    cmp("jump_count",   jumpCount,     e.jumpCount,    e.cycle);
  endtask

  always @(negedge clk) begin
    expect_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    // Two reset cycles, then the single IDLE cycle and a few quiet RUN cycles.
    applyStimulus(1, 0, 16'h0, 0, 0, 0);
    applyStimulus(1, 0, 16'h0, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 16'h0, 0, 0, 0);

    // Jump in RUN, flush, back to RUN.
    applyStimulus(0, 1, 16'h0040, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 16'h0, 0, 0, 0);

    // Single-cycle hazard pulse, then a hazard held for five cycles.
    applyStimulus(0, 0, 16'h0, 1, 0, 0);
    repeat (5) applyStimulus(0, 0, 16'h0, 0, 0, 0);
    repeat (5) applyStimulus(0, 0, 16'h0, 1, 0, 0);
    repeat (6) applyStimulus(0, 0, 16'h0, 0, 0, 0);

    // Jump arriving in the second stall cycle.
    applyStimulus(0, 0, 16'h0, 1, 0, 0);
    applyStimulus(0, 0, 16'h0, 0, 0, 0);
    applyStimulus(0, 1, 16'h1234, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 16'h0, 0, 0, 0);

    // Back-to-back jumps hold FLUSH; hazard/halt are ignored there.
    applyStimulus(0, 1, 16'hAAAA, 0, 0, 0);
    applyStimulus(0, 1, 16'h5555, 0, 0, 0);
    applyStimulus(0, 0, 16'h0, 1, 1, 0);
    repeat (2) applyStimulus(0, 0, 16'h0, 0, 0, 0);

    // Halt, ignored jump, resume blocked by halt_req, then a clean resume.
    applyStimulus(0, 0, 16'h0, 0, 1, 0);
    applyStimulus(0, 1, 16'hBEEF, 0, 0, 0);
    applyStimulus(0, 0, 16'h0, 0, 1, 1);
    applyStimulus(0, 0, 16'h0, 0, 0, 1);
    repeat (2) applyStimulus(0, 0, 16'h0, 0, 0, 0);

    // Reset mid-STALL and mid-HALT.
    applyStimulus(0, 0, 16'h0, 1, 0, 0);
    applyStimulus(0, 0, 16'h0, 0, 0, 0);
    applyStimulus(1, 0, 16'h0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 16'h0, 0, 0, 0);
    applyStimulus(0, 0, 16'h0, 0, 1, 0);
    applyStimulus(0, 0, 16'h0, 0, 0, 0);
    applyStimulus(1, 1, 16'h7777, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 16'h0, 0, 0, 0);

    // Long halt to push the stall counter past saturation.
    repeat (70000) applyStimulus(0, 0, 16'h0, 0, 1, 0);
    applyStimulus(0, 0, 16'h0, 0, 0, 1);
    repeat (3) applyStimulus(0, 0, 16'h0, 0, 0, 0);

    // Randomized traffic with occasional resets.
    repeat (3000) begin
      applyStimulus(($urandom_range(63) == 0), ($urandom_range(5) == 0), 16'($urandom),
                    ($urandom_range(4) == 0), ($urandom_range(9) == 0), ($urandom_range(3) == 0));
    end

    repeat (2) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter HAZARD_STALL_CYCLES, default 1, meaning the minimum fetch-stall length per hazard; legal range 1..15.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning the program-memory address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port jump_req, input, 1 bit: decode requests a taken jump/branch this cycle.
REQ-006 SHALL have port jump_addr, input, ADDR_W bits: the jump target.
REQ-007 SHALL have port hazard, input, 1 bit: decode detects a load-use hazard.
REQ-008 SHALL have ports halt_req and resume, inputs, 1 bit each: debug halt and resume.
REQ-009 SHALL have port pc_mux_sel, output, 1 bit: selects jmp_loc as the next fetch address.
REQ-010 SHALL have port jmp_loc, output, ADDR_W bits: the jump address driven to program memory.
REQ-011 SHALL have ports stall and stall_pm, outputs, 1 bit each: hold the PC and hold the instruction register.
REQ-012 SHALL have ports flush, jump_ack and halted, outputs, 1 bit each.
REQ-013 SHALL have ports stall_cycles and jump_count, outputs, 16 bits each: performance counters.

Function
REQ-014 SHALL implement the states IDLE, RUN, STALL, FLUSH and HALT.
REQ-015 SHALL go from IDLE to RUN unconditionally after one cycle, asserting stall=stall_pm=1 while in IDLE.
REQ-016 SHALL apply priority jump_req > hazard > halt_req in RUN.
REQ-017 SHALL accept jump_req in RUN, STALL and FLUSH: in that cycle pc_mux_sel=1, jmp_loc=jump_addr (combinational) and jump_ack=1; the next state is FLUSH.
REQ-018 SHALL cancel a pending stall and reset the stall counter when a jump is accepted in STALL.
REQ-019 SHALL ignore jump_req in IDLE and HALT; in those states pc_mux_sel=0 and jump_ack=0.
REQ-020 SHALL drive jmp_loc to 0 whenever pc_mux_sel=0.
REQ-021 SHALL assert flush for exactly one cycle in FLUSH so that decode treats ins as a NOP, then go to RUN; back-to-back jumps keep the block in FLUSH.
REQ-022 SHALL ignore hazard and halt_req while in FLUSH.
REQ-023 SHALL, on hazard in RUN without jump_req, enter STALL and load a 4-bit counter with HAZARD_STALL_CYCLES-1.
REQ-024 SHALL assert stall=stall_pm=1 throughout STALL.
REQ-025 SHALL decrement the counter each STALL cycle and leave for RUN when the counter is 0 and hazard=0; if hazard=1 at counter 0, it stays in STALL and reloads.
REQ-026 SHALL, on halt_req in RUN without jump_req or hazard, enter HALT.
REQ-027 SHALL assert stall=stall_pm=halted=1 in HALT.
REQ-028 SHALL leave HALT for RUN on resume=1 with halt_req=0; if halt_req and resume are both 1, it stays in HALT.
REQ-029 SHALL hold stall=stall_pm=flush=0 in RUN.
REQ-030 SHALL make stall, stall_pm, flush and halted Moore outputs of the registered state.

Reset
REQ-031 SHALL, with reset=1 at a clock edge, enter IDLE from any state and clear the stall counter and performance counters.
REQ-032 SHALL force pc_mux_sel=0, jump_ack=0 and jmp_loc=0 combinationally while reset=1.
REQ-033 SHALL discard an in-progress stall, flush or halt on reset without any extra cycle.
REQ-034 SHALL hold reset values of flush=halted=0 and stall_cycles=jump_count=0, with stall=stall_pm=1 (IDLE).

Configuration
REQ-035 SHALL, with FETCH_PERF_CNT_EN defined, increment stall_cycles each cycle stall=1 outside IDLE and increment jump_count on each jump_ack, both saturating at 16'hFFFF.
REQ-036 SHALL, without FETCH_PERF_CNT_EN, keep the ports but tie stall_cycles and jump_count to 0, with no counter flops.

Structure
REQ-037 SHALL take the state encoding typedef, ADDR_W default, counter width (16) and saturation constant from the shared package fetch_ctrl_pkg.
REQ-038 SHALL implement the saturating counters as sub-module sat_counter, instantiated twice under FETCH_PERF_CNT_EN.

Verification
REQ-039 SHALL cover: reset for 2 cycles, then release -> IDLE for 1 cycle with stall=stall_pm=1, then RUN with all strobes 0 and counters 0.
REQ-040 SHALL cover: jump_req=1, jump_addr=16'h0040 in RUN -> same-cycle pc_mux_sel=1, jmp_loc=16'h0040, jump_ack=1; next cycle flush=1; then RUN; jump_count=1.
REQ-041 SHALL cover: HAZARD_STALL_CYCLES=3, hazard pulsed for 1 cycle -> stall=stall_pm=1 for exactly 3 cycles; with hazard held for 5 cycles -> 6 stall cycles; stall_cycles matches.
REQ-042 SHALL cover: jump_req during the second STALL cycle -> jump accepted, stall drops the next cycle, flush=1 for one cycle.
REQ-043 SHALL cover: halt_req in RUN -> halted=1; jump_req in HALT -> pc_mux_sel=0; resume with halt_req=1 -> still HALT; resume alone -> RUN.
REQ-044 SHALL cover: reset asserted mid-STALL and mid-HALT -> IDLE next edge with counters 0; with 70000 forced stall cycles, stall_cycles saturates at 16'hFFFF (macro defined) or reads 0 (macro undefined).
